// File: rtl/minibyte_bus_arbiter.sv
`timescale 1ns/1ps
// Two-requester round-robin arbiter that sequences the Minibyte memory bus:
// one fixed-shape ADDR / WAIT* / STROBE / ACK cycle per granted request.
module minibyte_bus_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int WAIT_W = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [WAIT_W-1:0] wait_cfg_in,
  input  logic              r0_req_in,
  input  logic              r0_we_in,
  input  logic [ADDR_W-1:0] r0_addr_in,
  input  logic [DATA_W-1:0] r0_data_in,
  output logic              r0_ack_out,
  output logic [DATA_W-1:0] r0_data_out,
  input  logic              r1_req_in,
  input  logic              r1_we_in,
  input  logic [ADDR_W-1:0] r1_addr_in,
  input  logic [DATA_W-1:0] r1_data_in,
  output logic              r1_ack_out,
  output logic [DATA_W-1:0] r1_data_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_we_out,
  output logic              bus_drive_out,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              busy_out,
  output logic              owner_out
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_STROBE, S_ACK} state_t;

  state_t              state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                gnt;

  logic                busy_q, drive_q, bus_we_q, ack0_q, ack1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    gnt          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (r0_req_in || r1_req_in) begin
          // On a tie the requester that did not win last time gets the bus.
          gnt          = (r0_req_in && r1_req_in) ? ~last_owner_q : r1_req_in;
          owner_d      = gnt;
          last_owner_d = gnt;
          we_d         = gnt ? r1_we_in   : r0_we_in;
          addr_d       = gnt ? r1_addr_in : r0_addr_in;
          wdata_d      = gnt ? r1_data_in : r0_data_in;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = wait_cfg_in;
        state_d = (wait_cfg_in != '0) ? S_WAIT : S_STROBE;
      end
      S_WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q <= WAIT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      drive_q      <= 1'b0;
      bus_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      busy_q       <= (state_d != S_IDLE);
      drive_q      <= we_d && ((state_d == S_ADDR) || (state_d == S_WAIT) ||
                               (state_d == S_STROBE));
      bus_we_q     <= we_d && (state_d == S_STROBE);
      ack0_q       <= (state_d == S_ACK) && !owner_d;
      ack1_q       <= (state_d == S_ACK) && owner_d;
      if ((state_q == S_STROBE) && !we_q) begin
        if (owner_q) rdata1_q <= bus_data_in;
        else         rdata0_q <= bus_data_in;
      end
    end
  end

  assign r0_ack_out    = ack0_q;
  assign r1_ack_out    = ack1_q;
  assign r0_data_out   = rdata0_q;
  assign r1_data_out   = rdata1_q;
  assign bus_addr_out  = addr_q;
  assign bus_data_out  = wdata_q;
  assign bus_we_out    = bus_we_q;
  assign bus_drive_out = drive_q;
  assign busy_out      = busy_q;
  assign owner_out     = owner_q;

endmodule
